// File: rtl/iq_select_scheduler.sv
// rtl/iq_select_scheduler.sv - wakeup/select controller for the 8-entry issue queue
//
// Tracks per-slot valid/issued/source-ready state and snoops two writeback tag
// broadcasts. On every edge it picks up to two eligible slots and presents them
// as registered pop requests to two execution ports. A port whose pop is not yet
// acknowledged holds its request and makes no new pick.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   flush                           clears all state except alloc_err
//   alloc0/1, alloc_key0/1          dispatch writes (alloc0 is the older one)
//   alloc_tag_a/b0/1, alloc_rdy_a/b0/1  source tags and ready-at-dispatch bits
//   wake0/1, wake_tag0/1            writeback tag broadcasts
//   pop0/1, pop_key0/1              registered issue requests per port
//   ack0/1                          port accepts its current pop
//   free                            registered count of invalid slots
//   alloc_err                       sticky protocol error (cleared by reset only)
//
// Build option: define IQ_SCHED_AGE_EN to select the oldest eligible slot using
// an age matrix; otherwise the lowest eligible slot index wins.

module iq_select_scheduler #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_W       = 3,
  parameter int TAG_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc0,
  input  logic [KEY_W-1:0] alloc_key0,
  input  logic [TAG_W-1:0] alloc_tag_a0,
  input  logic [TAG_W-1:0] alloc_tag_b0,
  input  logic             alloc_rdy_a0,
  input  logic             alloc_rdy_b0,
  input  logic             alloc1,
  input  logic [KEY_W-1:0] alloc_key1,
  input  logic [TAG_W-1:0] alloc_tag_a1,
  input  logic [TAG_W-1:0] alloc_tag_b1,
  input  logic             alloc_rdy_a1,
  input  logic             alloc_rdy_b1,
  input  logic             wake0,
  input  logic [TAG_W-1:0] wake_tag0,
  input  logic             wake1,
  input  logic [TAG_W-1:0] wake_tag1,
  output logic             pop0,
  output logic [KEY_W-1:0] pop_key0,
  output logic             pop1,
  output logic [KEY_W-1:0] pop_key1,
  input  logic             ack0,
  input  logic             ack1,
  output logic [KEY_W:0]   free,
  output logic             alloc_err
);

  logic [NUM_ENTRIES-1:0]            valid_q, issued_q, rdy_a_q, rdy_b_q;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] tag_a_q, tag_b_q;

  logic [NUM_ENTRIES-1:0]            valid_d, issued_d, rdy_a_d, rdy_b_d;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0] tag_a_d, tag_b_d;

  logic [NUM_ENTRIES-1:0] hit_a, hit_b, ack_mask, live, elig, cand0, cand1;
  logic                   hold0, hold1;
  logic [KEY_W:0]         sel0, sel1;
  logic                   alloc0_ok, alloc1_ok, err_set;
  logic                   pop0_d, pop1_d;
  logic [KEY_W-1:0]       pop_key0_d, pop_key1_d;
  logic [KEY_W:0]         free_d;

  function automatic logic wake_hit(input logic [TAG_W-1:0] tag,
                                    input logic w0, input logic [TAG_W-1:0] t0,
                                    input logic w1, input logic [TAG_W-1:0] t1);
    return (w0 && (tag == t0)) || (w1 && (tag == t1));
  endfunction

`ifdef IQ_SCHED_AGE_EN
  // older_q[j][i] = 1 means slot j was allocated before slot i.
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;

  // Oldest candidate: no other candidate is older. Lowest index breaks any tie.
  function automatic logic [KEY_W:0] pick_best(
      input logic [NUM_ENTRIES-1:0]                  mask,
      input logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older);
    logic [NUM_ENTRIES-1:0] oldest;
    logic [KEY_W:0]         r;
    oldest = '0;
    r      = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      oldest[i] = mask[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (mask[j] && older[j][i]) oldest[i] = 1'b0;
      end
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (oldest[i]) r = {1'b1, KEY_W'(i)};
    end
    return r;
  endfunction
`else
  function automatic logic [KEY_W:0] pick_best(input logic [NUM_ENTRIES-1:0] mask);
    logic [KEY_W:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, KEY_W'(i)};
    end
    return r;
  endfunction
`endif

  always_comb begin
    hit_a    = '0;
    hit_b    = '0;
    ack_mask = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_a[i] = wake_hit(tag_a_q[i], wake0, wake_tag0, wake1, wake_tag1);
      hit_b[i] = wake_hit(tag_b_q[i], wake0, wake_tag0, wake1, wake_tag1);
    end
    if (pop0 && ack0) ack_mask[pop_key0] = 1'b1;
    if (pop1 && ack1) ack_mask[pop_key1] = 1'b1;

    live  = valid_q & ~ack_mask;
    // Wakeups this cycle count toward this cycle's selection.
    elig  = live & ~issued_q & (rdy_a_q | hit_a) & (rdy_b_q | hit_b);
    hold0 = pop0 && !ack0;
    hold1 = pop1 && !ack1;

    cand0 = hold0 ? '0 : elig;
`ifdef IQ_SCHED_AGE_EN
    sel0  = pick_best(cand0, older_q);
`else
    sel0  = pick_best(cand0);
`endif
    cand1 = hold1 ? '0 : elig;
    if (sel0[KEY_W]) cand1[sel0[KEY_W-1:0]] = 1'b0;
`ifdef IQ_SCHED_AGE_EN
    sel1  = pick_best(cand1, older_q);
`else
    sel1  = pick_best(cand1);
`endif

    pop0_d     = hold0 ? 1'b1 : sel0[KEY_W];
    pop_key0_d = (!hold0 && sel0[KEY_W]) ? sel0[KEY_W-1:0] : pop_key0;
    pop1_d     = hold1 ? 1'b1 : sel1[KEY_W];
    pop_key1_d = (!hold1 && sel1[KEY_W]) ? sel1[KEY_W-1:0] : pop_key1;

    // A slot being acked this edge may be rewritten by dispatch.
    alloc0_ok = alloc0 && !live[alloc_key0];
    alloc1_ok = alloc1 && !live[alloc_key1] && !(alloc0 && (alloc_key1 == alloc_key0));
    err_set   = (alloc0 && !alloc0_ok) || (alloc1 && !alloc1_ok);

    valid_d  = live;
    issued_d = issued_q & ~ack_mask;
    rdy_a_d  = rdy_a_q | hit_a;
    rdy_b_d  = rdy_b_q | hit_b;
    tag_a_d  = tag_a_q;
    tag_b_d  = tag_b_q;
    if (sel0[KEY_W]) issued_d[sel0[KEY_W-1:0]] = 1'b1;
    if (sel1[KEY_W]) issued_d[sel1[KEY_W-1:0]] = 1'b1;

    if (alloc0_ok) begin
      valid_d[alloc_key0]  = 1'b1;
      issued_d[alloc_key0] = 1'b0;
      tag_a_d[alloc_key0]  = alloc_tag_a0;
      tag_b_d[alloc_key0]  = alloc_tag_b0;
      rdy_a_d[alloc_key0]  = alloc_rdy_a0 || wake_hit(alloc_tag_a0, wake0, wake_tag0, wake1, wake_tag1);
      rdy_b_d[alloc_key0]  = alloc_rdy_b0 || wake_hit(alloc_tag_b0, wake0, wake_tag0, wake1, wake_tag1);
    end
    if (alloc1_ok) begin
      valid_d[alloc_key1]  = 1'b1;
      issued_d[alloc_key1] = 1'b0;
      tag_a_d[alloc_key1]  = alloc_tag_a1;
      tag_b_d[alloc_key1]  = alloc_tag_b1;
      rdy_a_d[alloc_key1]  = alloc_rdy_a1 || wake_hit(alloc_tag_a1, wake0, wake_tag0, wake1, wake_tag1);
      rdy_b_d[alloc_key1]  = alloc_rdy_b1 || wake_hit(alloc_tag_b1, wake0, wake_tag0, wake1, wake_tag1);
    end

`ifdef IQ_SCHED_AGE_EN
    older_d = older_q;
    if (alloc0_ok) begin
      for (int j = 0; j < NUM_ENTRIES; j++) older_d[j][alloc_key0] = live[j];
      older_d[alloc_key0] = '0;
    end
    if (alloc1_ok) begin
      // alloc0 is the older of a same-cycle pair.
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        older_d[j][alloc_key1] = live[j] || (alloc0_ok && (KEY_W'(j) == alloc_key0));
      end
      older_d[alloc_key1] = '0;
    end
`endif

    free_d = (KEY_W+1)'(NUM_ENTRIES);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_d = free_d - (KEY_W+1)'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q  <= '0;
      issued_q <= '0;
      rdy_a_q  <= '0;
      rdy_b_q  <= '0;
      tag_a_q  <= '0;
      tag_b_q  <= '0;
      pop0     <= 1'b0;
      pop1     <= 1'b0;
      pop_key0 <= '0;
      pop_key1 <= '0;
      free     <= (KEY_W+1)'(NUM_ENTRIES);
`ifdef IQ_SCHED_AGE_EN
      older_q  <= '0;
`endif
      if (reset) alloc_err <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      issued_q  <= issued_d;
      rdy_a_q   <= rdy_a_d;
      rdy_b_q   <= rdy_b_d;
      tag_a_q   <= tag_a_d;
      tag_b_q   <= tag_b_d;
      pop0      <= pop0_d;
      pop1      <= pop1_d;
      pop_key0  <= pop_key0_d;
      pop_key1  <= pop_key1_d;
      free      <= free_d;
`ifdef IQ_SCHED_AGE_EN
      older_q   <= older_d;
`endif
      alloc_err <= alloc_err || err_set;
    end
  end

endmodule
